// File: rtl/fir_pkg.sv
// Shared widths, rounding/saturation constants and the coefficient-bank type
// for the decimate-by-4 time-shared FIR.
package fir_pkg;

    localparam int DEF_FILTERBITWIDTH = 18;
    localparam int DEF_COEBITWIDTH    = 16;
    localparam int DEF_NTAPS          = 16;

    localparam int ACCBITWIDTH = DEF_FILTERBITWIDTH + DEF_COEBITWIDTH + $clog2(DEF_NTAPS);
    localparam int CNT_W       = 2;
    localparam int ADDR_W      = $clog2(DEF_NTAPS);

    localparam int     RND_SHIFT = DEF_COEBITWIDTH - 1;
    localparam longint RND_HALF  = 64'sd1 <<< (DEF_COEBITWIDTH - 2);
    localparam int     SAT_MAX   = (2 ** (DEF_FILTERBITWIDTH - 1)) - 1;
    localparam int     SAT_MIN   = -(2 ** (DEF_FILTERBITWIDTH - 1));

    localparam logic [CNT_W-1:0] PHASE_LAST = 2'd3;

    typedef logic signed [DEF_COEBITWIDTH-1:0] coef_arr_t [DEF_NTAPS];

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturation of the wide accumulator
// down to the output sample width, with an overflow flag.
module fir_round_sat #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 18,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  i_acc,
    output logic signed [OUT_W-1:0] o_y,
    output logic                    o_ovf
);

    localparam int Y_W = IN_W + 1 - SHIFT;

    // One guard bit on top keeps the +half from wrapping at the positive limit.
    function automatic logic signed [Y_W-1:0] round_shift(input logic signed [IN_W-1:0] a);
        logic signed [IN_W:0] t;
        t = $signed({a[IN_W-1], a}) +
            $signed({{(IN_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}});
        return t[IN_W:SHIFT];
    endfunction

    function automatic logic [OUT_W:0] saturate(input logic signed [Y_W-1:0] y);
        logic fits;
        fits = (y[Y_W-1:OUT_W-1] == {(Y_W - OUT_W + 1){y[Y_W-1]}});
        if (fits)
            return {1'b0, y[OUT_W-1:0]};
        else if (y[Y_W-1])
            return {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
    endfunction

    logic signed [Y_W-1:0] w_y;
    logic [OUT_W:0]        w_sat;

    assign w_y   = round_shift(i_acc);
    assign w_sat = saturate(w_y);
    assign o_y   = $signed(w_sat[OUT_W-1:0]);
    assign o_ovf = w_sat[OUT_W];

endmodule

// File: rtl/fir_decim4_mac.sv
// Decimate-by-4 FIR: snapshot every 4th sample, four MAC groups over four
// clocks, rounded/saturated output 6 clocks after the snapshot.
module fir_decim4_mac
    import fir_pkg::*;
#(
    parameter int FILTERBITWIDTH = DEF_FILTERBITWIDTH,
    parameter int COEBITWIDTH    = DEF_COEBITWIDTH,
    parameter int NTAPS          = DEF_NTAPS
) (
    input  logic                             clk,
    input  logic                             rst_param,
    input  logic                             rst,
    input  logic signed [FILTERBITWIDTH-1:0] data_in,
    input  logic                             coe_indicator,
    input  logic [$clog2(NTAPS)-1:0]         coe_addr,
    input  logic signed [COEBITWIDTH-1:0]    coe_param,
    input  logic                             config_sync,
    output logic signed [FILTERBITWIDTH-1:0] data_out,
    output logic                             data_valid,
    output logic                             overflow_reg
);

    localparam int TAPS_PER_CYC = NTAPS / 4;
    localparam int ACC_W        = FILTERBITWIDTH + COEBITWIDTH + $clog2(NTAPS);
    localparam int PROD_W       = FILTERBITWIDTH + COEBITWIDTH;
    localparam int A_W          = $clog2(NTAPS);

    logic signed [COEBITWIDTH-1:0]    r_shadow [NTAPS];
    logic signed [COEBITWIDTH-1:0]    r_active [NTAPS];

    logic signed [FILTERBITWIDTH-1:0] r_x      [NTAPS-1];
    logic signed [FILTERBITWIDTH-1:0] r_snap   [NTAPS];
    logic [CNT_W-1:0]                 r_cnt;
    logic [CNT_W-1:0]                 r_grp;
    logic                             r_vld_p0;

    logic signed [PROD_W-1:0]         r_prod_p1 [TAPS_PER_CYC];
    logic                             r_vld_p1;
    logic                             r_first_p1;
    logic                             r_last_p1;

    logic signed [ACC_W-1:0]          r_acc_p2;
    logic                             r_vld_p2;

    logic signed [FILTERBITWIDTH-1:0] r_data_out;
    logic                             r_data_valid;
    logic                             r_overflow;

    logic [A_W-1:0]                   w_idx  [TAPS_PER_CYC];
    logic signed [PROD_W-1:0]         w_prod [TAPS_PER_CYC];
    logic signed [ACC_W-1:0]          w_sum;
    logic signed [FILTERBITWIDTH-1:0] w_y;
    logic                             w_ovf;

    // Writes only ever touch the shadow bank; a same-edge sync copies the pre-write shadow.
    always_ff @(posedge clk or negedge rst_param) begin
        if (!rst_param) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (coe_indicator)
                r_shadow[coe_addr] <= coe_param;
            if (config_sync)
                r_active <= r_shadow;
        end
    end

    // ---- stage p0 -> p1: one group of TAPS_PER_CYC products from the snapshot
    always_comb begin
        for (int j = 0; j < TAPS_PER_CYC; j++) begin
            w_idx[j]  = A_W'(int'(r_grp) * TAPS_PER_CYC + j);
            w_prod[j] = PROD_W'(r_snap[w_idx[j]]) * PROD_W'(r_active[w_idx[j]]);
        end
    end

    // ---- stage p1 -> p2: sign-extended sum of the registered products
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < TAPS_PER_CYC; j++)
            w_sum = w_sum + ACC_W'(r_prod_p1[j]);
    end

    // ---- stage p2 -> out: round and saturate the finished accumulation
    fir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (FILTERBITWIDTH),
        .SHIFT (COEBITWIDTH - 1)
    ) u_round_sat (
        .i_acc (r_acc_p2),
        .o_y   (w_y),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS - 1; i++)
                r_x[i] <= '0;
            for (int i = 0; i < NTAPS; i++)
                r_snap[i] <= '0;
            for (int j = 0; j < TAPS_PER_CYC; j++)
                r_prod_p1[j] <= '0;
            r_cnt        <= '0;
            r_grp        <= '0;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_first_p1   <= 1'b0;
            r_last_p1    <= 1'b0;
            r_acc_p2     <= '0;
            r_vld_p2     <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_x[0] <= data_in;
            for (int i = 1; i < NTAPS - 1; i++)
                r_x[i] <= r_x[i-1];
            r_data_valid <= 1'b0;

            if (config_sync) begin
                // Realign phase and drop everything in flight; the delay line survives.
                r_cnt    <= '0;
                r_grp    <= '0;
                r_vld_p0 <= 1'b0;
                r_vld_p1 <= 1'b0;
                r_vld_p2 <= 1'b0;
                r_acc_p2 <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);

                r_vld_p1   <= r_vld_p0;
                r_first_p1 <= (r_grp == '0);
                r_last_p1  <= (r_grp == PHASE_LAST);
                if (r_vld_p0) begin
                    r_prod_p1 <= w_prod;
                    r_grp     <= r_grp + CNT_W'(1);
                    if (r_grp == PHASE_LAST)
                        r_vld_p0 <= 1'b0;
                end

                // A new snapshot lands on the same edge the previous group 3 is taken.
                if (r_cnt == PHASE_LAST) begin
                    r_snap[0] <= data_in;
                    for (int i = 1; i < NTAPS; i++)
                        r_snap[i] <= r_x[i-1];
                    r_grp    <= '0;
                    r_vld_p0 <= 1'b1;
                end

                if (r_vld_p1)
                    r_acc_p2 <= r_first_p1 ? w_sum : r_acc_p2 + w_sum;
                r_vld_p2 <= r_vld_p1 && r_last_p1;

                if (r_vld_p2) begin
                    r_data_out   <= w_y;
                    r_overflow   <= w_ovf;
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign overflow_reg = r_overflow;

endmodule

// File: tb/tb_fir_decim4_mac.sv
// Directed and randomized checks of fir_decim4_mac against a sample-history
// reference model that evaluates the decimated convolution directly.
module tb_fir_decim4_mac;
    import fir_pkg::*;

    localparam int NT = 16;

    logic               clk = 1'b0;
    logic               rst_param;
    logic               rst;
    logic signed [17:0] data_in;
    logic               coe_indicator;
    logic [3:0]         coe_addr;
    logic signed [15:0] coe_param;
    logic               config_sync;
    logic signed [17:0] data_out;
    logic               data_valid;
    logic               overflow_reg;

    always #5 clk = ~clk;

    fir_decim4_mac dut (
        .clk           (clk),
        .rst_param     (rst_param),
        .rst           (rst),
        .data_in       (data_in),
        .coe_indicator (coe_indicator),
        .coe_addr      (coe_addr),
        .coe_param     (coe_param),
        .config_sync   (config_sync),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .overflow_reg  (overflow_reg)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         due;
        logic [17:0] y;
        logic       ovf;
        bit         chk;
    } pend_t;

    pend_t       pend[$];
    coef_arr_t   m_act;
    coef_arr_t   m_shd;
    longint      hist[NT];
    int          cyc  = 0;
    int          mcnt = 0;
    bit          exp_valid;
    bit          exp_chk;
    logic [17:0] exp_y;
    logic        exp_ovf;

    logic [17:0] last_out;
    logic        last_ovf;
    logic [17:0] obs_q[$];
    bit          rec_on = 1'b0;
    int          rec_from = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void scale(input longint acc, output logic [17:0] y, output logic ovf);
        longint v;
        v = (acc + 64'sd16384) >>> 15;
        if (v > 131071) begin
            y = 18'h1FFFF; ovf = 1'b1;
        end else if (v < -131072) begin
            y = 18'h20000; ovf = 1'b1;
        end else begin
            y = v[17:0];   ovf = 1'b0;
        end
    endfunction

    task automatic model_rst();
        pend.delete();
        mcnt = 0;
        for (int i = 0; i < NT; i++) hist[i] = 0;
    endtask

    task automatic model_rst_param();
        for (int i = 0; i < NT; i++) begin
            m_act[i] = '0;
            m_shd[i] = '0;
        end
        foreach (pend[k]) pend[k].chk = 1'b0;
    endtask

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_edge();
        longint      din;
        longint      acc;
        logic [17:0] y;
        logic        ovf;
        pend_t       p;
        cyc++;
        exp_valid = 1'b0;
        if (rst) begin
            din = longint'(data_in);
            if (config_sync) begin
                pend.delete();
                mcnt = 0;
            end else begin
                if (mcnt == 3) begin
                    acc = din * longint'(m_act[0]);
                    for (int i = 1; i < NT; i++)
                        acc += hist[i-1] * longint'(m_act[i]);
                    scale(acc, y, ovf);
                    pend.push_back('{due: cyc + 6, y: y, ovf: ovf, chk: 1'b1});
                end
                mcnt = (mcnt + 1) % 4;
            end
            for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p         = pend.pop_front();
                exp_valid = 1'b1;
                exp_chk   = p.chk;
                exp_y     = p.y;
                exp_ovf   = p.ovf;
            end
        end
        if (rst_param) begin
            if (config_sync) m_act = m_shd;
            if (coe_indicator) m_shd[coe_addr] = coe_param;
        end
    endtask

    task automatic check_outputs();
        chk("data_valid", {31'd0, data_valid}, {31'd0, exp_valid});
        if (exp_valid && exp_chk) begin
            chk("data_out", {14'd0, data_out}, {14'd0, exp_y});
            chk("overflow_reg", {31'd0, overflow_reg}, {31'd0, exp_ovf});
        end
        if (data_valid) begin
            last_out = data_out;
            last_ovf = overflow_reg;
            if (rec_on && cyc >= rec_from) obs_q.push_back(data_out);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic write_coef(input int addr, input logic signed [15:0] val);
        coe_indicator = 1'b1;
        coe_addr      = 4'(addr);
        coe_param     = val;
        step();
        coe_indicator = 1'b0;
    endtask

    task automatic do_sync();
        config_sync = 1'b1;
        step();
        config_sync = 1'b0;
    endtask

    initial begin
        logic [17:0] imp_exp [5];
        int          k;
        int          nonzero;
        bit          found;

        imp_exp[0] = 18'd1024;  imp_exp[1] = 18'd5120; imp_exp[2] = 18'd9216;
        imp_exp[3] = 18'd13312; imp_exp[4] = 18'd0;

        rst = 1'b0; rst_param = 1'b0;
        data_in = '0; coe_indicator = 1'b0; coe_addr = '0; coe_param = '0; config_sync = 1'b0;
        model_rst();
        model_rst_param();
        step();
        step();
        chk("rst_data_out", {14'd0, data_out}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_reg}, 32'd0);
        rst = 1'b1; rst_param = 1'b1;

        // Impulse response, also measuring sync-to-first-valid latency.
        for (int i = 0; i < NT; i++) write_coef(i, 16'((i + 1) * 1024));
        do_sync();
        k = 0; found = 1'b0;
        for (int s = 1; s <= 20 && !found; s++) begin
            step();
            if (data_valid) begin found = 1'b1; k = s; end
        end
        chk("sync_latency", k, 32'd10);
        for (int s = 0; s < 4 && mcnt != 3; s++) step();
        data_in = 18'sh08000;
        step();
        data_in = '0;
        rec_from = cyc + 6; rec_on = 1'b1; obs_q.delete();
        repeat (22) step();
        rec_on = 1'b0;
        chk("impulse_count", obs_q.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < obs_q.size()) chk($sformatf("impulse_%0d", i), {14'd0, obs_q[i]}, {14'd0, imp_exp[i]});

        repeat (40) begin data_in = 18'($urandom()); step(); end

        // Positive and negative saturation.
        data_in = 18'sh1FFFF;
        for (int i = 0; i < NT; i++) write_coef(i, 16'sh7FFF);
        do_sync();
        last_out = '0; last_ovf = 1'b0;
        repeat (20) step();
        chk("sat_pos_out", {14'd0, last_out}, 32'h1FFFF);
        chk("sat_pos_ovf", {31'd0, last_ovf}, 32'd1);
        data_in = 18'sh20000;
        repeat (16) step();
        last_out = '0; last_ovf = 1'b0;
        repeat (8) step();
        chk("sat_neg_out", {14'd0, last_out}, 32'h20000);
        chk("sat_neg_ovf", {31'd0, last_ovf}, 32'd1);

        // Rounding with a single LSB coefficient.
        data_in = 18'sh04000;
        write_coef(0, 16'sh0001);
        for (int i = 1; i < NT; i++) write_coef(i, 16'sh0000);
        do_sync();
        last_out = 18'h2AAAA; last_ovf = 1'b1;
        repeat (14) step();
        chk("round_up_out", {14'd0, last_out}, 32'd1);
        chk("round_up_ovf", {31'd0, last_ovf}, 32'd0);
        data_in = 18'sh3C000;
        last_out = 18'h2AAAA; last_ovf = 1'b1;
        repeat (8) step();
        chk("round_neg_out", {14'd0, last_out}, 32'd0);
        chk("round_neg_ovf", {31'd0, last_ovf}, 32'd0);

        // Bank swap: shadow-only write, write coincident with sync, then plain sync.
        data_in = 18'sh04000;
        write_coef(0, 16'sh2000);
        last_out = 18'h2AAAA;
        repeat (12) step();
        chk("noswap_old_coef", {14'd0, last_out}, 32'd1);
        coe_indicator = 1'b1; coe_addr = 4'd0; coe_param = 16'sh4000; config_sync = 1'b1;
        step();
        coe_indicator = 1'b0; config_sync = 1'b0;
        last_out = 18'h2AAAA;
        repeat (14) step();
        chk("write_sync_pre_write", {14'd0, last_out}, 32'd4096);
        do_sync();
        last_out = 18'h2AAAA;
        repeat (14) step();
        chk("second_sync_new_coef", {14'd0, last_out}, 32'd8192);

        // Random coefficients and data.
        for (int i = 0; i < NT; i++) write_coef(i, 16'($urandom()));
        do_sync();
        repeat (48) begin data_in = 18'($urandom()); step(); end

        // rst mid-frame: immediate clear, 10-clock restart, coefficients kept.
        repeat (2) begin data_in = 18'($urandom()); step(); end
        rst = 1'b0;
        model_rst();
        #1;
        chk("rst_mid_data_out", {14'd0, data_out}, 32'd0);
        chk("rst_mid_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_mid_ovf", {31'd0, overflow_reg}, 32'd0);
        repeat (3) begin data_in = 18'($urandom()); step(); end
        rst = 1'b1;
        k = 0; found = 1'b0;
        for (int s = 1; s <= 20 && !found; s++) begin
            data_in = 18'($urandom());
            step();
            if (data_valid) begin found = 1'b1; k = s; end
        end
        chk("rst_release_latency", k, 32'd10);
        repeat (20) begin data_in = 18'($urandom()); step(); end

        // rst_param alone clears both banks.
        rst_param = 1'b0;
        model_rst_param();
        repeat (3) begin data_in = 18'($urandom()); step(); end
        rst_param = 1'b1;
        do_sync();
        nonzero = 0;
        repeat (24) begin
            data_in = 18'($urandom());
            step();
            if (data_valid && data_out != '0) nonzero++;
        end
        chk("rst_param_zero_out", nonzero, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
